// File: rtl/sobel_gcd_spi_pkg.sv
// Shared SPI definitions for the sobel/GCD host link: master FSM states and frame width.
package sobel_gcd_spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_master_state_e;

  localparam int SPI_FRAME_BITS = 16;

endpackage

// File: rtl/spi_sck_tick_gen.sv
// Half-period tick generator for the SPI master: one tick every CLK_DIV clocks while not cleared.
module spi_sck_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic nreset_i,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == LAST_CNT) && !i_clear;

  // Divider counter, held at zero while cleared so the first half-period is full length.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_cnt <= '0;
    end else if (i_clear || (r_cnt == LAST_CNT)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sobel_gcd_spi_master.sv
// SPI mode-0 initiator (MSB first) for the sobel/GCD target port.
// Optional macro SOBEL_GCD_SPI_MASTER_LOOPBACK_EN adds loopback_i (capture MOSI instead of MISO).
module sobel_gcd_spi_master
  import sobel_gcd_spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = SPI_FRAME_BITS,
  parameter int CS_GAP     = 2
) (
  input  logic                  clk_i,
  input  logic                  nreset_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [FRAME_BITS-1:0] tx_data_i,
  output logic [FRAME_BITS-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  busy_o,
  output logic                  spi_sck_o,
  output logic                  spi_cs_o,
  output logic                  spi_sdo_o,
  input  logic                  spi_sdi_i
`ifdef SOBEL_GCD_SPI_MASTER_LOOPBACK_EN
  ,
  input  logic                  loopback_i
`endif
);

  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS);
  localparam logic [GW-1:0] LAST_GAP = GW'(CS_GAP - 1);

  spi_master_state_e     r_state;
  logic [BW-1:0]         r_bit_cnt;
  logic [GW-1:0]         r_gap_cnt;
  logic [FRAME_BITS-1:0] r_tx_sr;
  logic [FRAME_BITS-1:0] r_rx_sr;
  logic [FRAME_BITS-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_busy;
  logic                  r_ready;
  logic                  r_sck;
  logic                  r_cs;
  logic                  w_tick;
  logic                  w_tick_clear;
  logic                  w_miso;

  assign w_tick_clear = (r_state == IDLE) || (r_state == GAP);

`ifdef SOBEL_GCD_SPI_MASTER_LOOPBACK_EN
  assign w_miso = loopback_i ? r_tx_sr[FRAME_BITS-1] : spi_sdi_i;
`else
  assign w_miso = spi_sdi_i;
`endif

  spi_sck_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .i_clear  (w_tick_clear),
    .o_tick   (w_tick)
  );

  // Frame sequencer; MOSI is the shift register MSB, which is zeroed outside a frame.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b1;
      r_sck      <= 1'b0;
      r_cs       <= 1'b1;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid_i && r_ready) begin
            r_tx_sr   <= tx_data_i;
            r_rx_sr   <= '0;
            r_bit_cnt <= '0;
            r_cs      <= 1'b0;
            r_busy    <= 1'b1;
            r_ready   <= 1'b0;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          if (w_tick) begin
            r_sck     <= 1'b1;
            r_rx_sr   <= {r_rx_sr[FRAME_BITS-2:0], w_miso};
            r_bit_cnt <= BW'(1);
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_tick) begin
            if (r_sck) begin
              r_sck <= 1'b0;
              if (r_bit_cnt != LAST_BIT) begin
                r_tx_sr <= {r_tx_sr[FRAME_BITS-2:0], 1'b0};
              end
            end else if (r_bit_cnt == LAST_BIT) begin
              r_state <= HOLD;
            end else begin
              r_sck     <= 1'b1;
              r_rx_sr   <= {r_rx_sr[FRAME_BITS-2:0], w_miso};
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end
        end
        HOLD: begin
          if (w_tick) begin
            r_cs       <= 1'b1;
            r_rx_data  <= r_rx_sr;
            r_rx_valid <= 1'b1;
            r_tx_sr    <= '0;
            r_gap_cnt  <= '0;
            r_state    <= GAP;
          end
        end
        GAP: begin
          if (r_gap_cnt == LAST_GAP) begin
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        default: begin
          r_sck   <= 1'b0;
          r_cs    <= 1'b1;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o = r_ready;
  assign busy_o      = r_busy;
  assign rx_data_o   = r_rx_data;
  assign rx_valid_o  = r_rx_valid;
  assign spi_sck_o   = r_sck;
  assign spi_cs_o    = r_cs;
  assign spi_sdo_o   = r_tx_sr[FRAME_BITS-1];

endmodule
